icache_128: RTL
===============

// Module: icache_128
// PURPOSE
//  Direct-mapped, read-only instruction cache between the CPU fetch unit and the
//  inst port of ramctrl. Serves 32-bit instruction words from 128-bit (4-word)
//  lines. On a miss it fetches a whole line over the 25-bit line-address port,
//  fills the line and returns the word. A memory timeout is passed through, never cached.
// PARAMETERS
//  INDEX_BITS  8  line index width; LINES = 2**INDEX_BITS; tag width = 25-INDEX_BITS
// PORTS
//  clk          in   1    system clock
//  rst          in   1    reset, asynchronous, active-high
//  cpu_stb      in   1    fetch request; held with cpu_addr until cpu_ack/cpu_timeout
//  cpu_addr     in   27   word address; [26:2]=line address, [1:0]=word in line
//  cpu_dout     out  32   instruction word, valid while cpu_ack=1
//  cpu_ack      out  1    one-cycle pulse: cpu_dout valid, request done
//  cpu_timeout  out  1    one-cycle pulse: memory timed out, request done
//  mem_stb      out  1    line fetch request to ramctrl inst port
//  mem_addr     out  25   line address (= cpu_addr[26:2] latched at miss)
//  mem_din      in   128  line data from ramctrl; word0 = bits [31:0]
//  mem_ack      in   1    line data valid
//  mem_timeout  in   1    ramctrl timed out the request
// BEHAVIOUR
//  - Storage: data RAM LINES x 128, synchronous read; tag RAM LINES x tag width;
//    valid bits in flops, cleared by rst.
//  - Index = cpu_addr[INDEX_BITS+1:2]; tag = cpu_addr[26:INDEX_BITS+2].
//  - FSM states: IDLE, LOOKUP, FILL, REPLY, TMO.
//    IDLE:   cpu_stb=1 -> LOOKUP (RAM read of index issued on this edge).
//    LOOKUP: hit = valid[index] & tag match. Hit: cpu_ack=1, cpu_dout=RAM word
//            cpu_addr[1:0], -> IDLE. Miss: -> FILL, mem_addr latched.
//    FILL:   mem_stb=1 held. mem_ack: write line+tag, set valid, latch mem_din
//            into fill buffer, -> REPLY. mem_timeout: no write, -> TMO.
//            mem_ack and mem_timeout together: mem_ack wins.
//    REPLY:  cpu_ack=1, cpu_dout = fill buffer word cpu_addr[1:0], -> IDLE.
//    TMO:    cpu_timeout=1, cpu_dout=0, -> IDLE; valid[index] unchanged.
//  - Latency: hit = ack in 2nd cycle after cpu_stb first high; miss = ack one
//    cycle after mem_ack. cpu_stb high in the cycle after ack = new request.
//  - Outputs registered/decoded from state only; never combinational from cpu_stb.
//  - Reset values: state=IDLE, all valid=0, mem_stb=0, cpu_ack=0,
//    cpu_timeout=0, cpu_dout=0, mem_addr=0.
//  - Reset mid-fill: mem_stb drops at once; late mem_ack/mem_timeout seen in IDLE
//    or LOOKUP is ignored (no write, no ack).
//  - cpu_addr change without ack is a protocol violation; behaviour undefined.
//  - Index wrap: line addresses differing only in tag evict each other (direct map).
// CONFIGURATION
//  ICACHE_FLUSH_EN defined: extra input port flush (1 bit). flush=1 sampled in
//    IDLE clears all valid bits on that edge; the request (if cpu_stb) starts on
//    the next cycle. flush in other states is held pending until IDLE.
//  ICACHE_FLUSH_EN undefined: no flush port; valid bits cleared only by rst.
// TESTING
//  1 cold miss: rst, fetch word addr 0x0000010 -> mem_stb, mem_addr=0x0000004;
//    mem_din word0=0x11111111 -> cpu_ack next cycle, cpu_dout=0x11111111.
//  2 hit: then fetch 0x0000013 -> no mem_stb, cpu_ack 2nd cycle, dout=word3.
//  3 conflict: fetch 0x0040010 (same index, new tag) -> miss, refill; refetch
//    0x0000010 -> miss again.
//  4 timeout: miss with mem_timeout=1 -> cpu_timeout pulse, no cpu_ack;
//    same address again -> mem_stb again (not cached).
//  5 reset mid-fill: rst while mem_stb=1 -> mem_stb=0 at once; late mem_ack
//    ignored; next fetch of that line misses.
//  6 ICACHE_FLUSH_EN: fill 0x0000010, pulse flush in IDLE, refetch -> miss.

Source files
------------

// File: rtl/icache_128.sv
// icache_128: direct-mapped read-only instruction cache with 4-word lines; a miss fetches the whole line.
// Optional macro ICACHE_FLUSH_EN adds a flush input that invalidates every line.
module icache_128 #(
    parameter int INDEX_BITS = 8
) (
    input  logic         clk,
    input  logic         rst,
`ifdef ICACHE_FLUSH_EN
    input  logic         flush,
`endif
    input  logic         cpu_stb,
    input  logic [26:0]  cpu_addr,
    output logic [31:0]  cpu_dout,
    output logic         cpu_ack,
    output logic         cpu_timeout,
    output logic         mem_stb,
    output logic [24:0]  mem_addr,
    input  logic [127:0] mem_din,
    input  logic         mem_ack,
    input  logic         mem_timeout
);
    localparam int LINES = 2 ** INDEX_BITS;
    localparam int TAG_W = 25 - INDEX_BITS;

    typedef enum logic [2:0] {IDLE, LOOKUP, FILL, REPLY, TMO} state_t;

    state_t                state_q, state_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic [24:0]           mem_addr_q, mem_addr_d;
    logic [127:0]          fill_q, fill_d;

    logic [127:0]          data_ram [LINES];
    logic [TAG_W-1:0]      tag_ram  [LINES];
    logic [127:0]          rd_line_q;
    logic [TAG_W-1:0]      rd_tag_q;

    logic [INDEX_BITS-1:0] cpu_index;
    logic [INDEX_BITS-1:0] wr_index;
    logic [TAG_W-1:0]      cpu_tag;
    logic [6:0]            word_off;
    logic                  hit;
    logic                  ram_wr;
    logic                  flush_req;

    assign cpu_index = cpu_addr[INDEX_BITS+1:2];
    assign cpu_tag   = cpu_addr[26:INDEX_BITS+2];
    assign wr_index  = mem_addr_q[INDEX_BITS-1:0];
    assign word_off  = {cpu_addr[1:0], 5'b0};
    assign hit       = valid_q[cpu_index] && (rd_tag_q == cpu_tag);
    assign ram_wr    = (state_q == FILL) && mem_ack;
    assign mem_addr  = mem_addr_q;

`ifdef ICACHE_FLUSH_EN
    logic flush_pend_q, flush_pend_d;

    assign flush_req = flush | flush_pend_q;

    // A flush seen outside IDLE is remembered and applied on the next IDLE cycle.
    always_comb begin
        flush_pend_d = flush_pend_q;
        if (state_q == IDLE) begin
            flush_pend_d = 1'b0;
        end else if (flush) begin
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_pend_q <= 1'b0;
        end else begin
            flush_pend_q <= flush_pend_d;
        end
    end
`else
    assign flush_req = 1'b0;
`endif

    // Read port is driven every IDLE cycle so the data is ready in LOOKUP.
    always_ff @(posedge clk) begin
        if (state_q == IDLE) begin
            rd_line_q <= data_ram[cpu_index];
            rd_tag_q  <= tag_ram[cpu_index];
        end
        if (ram_wr) begin
            data_ram[wr_index] <= mem_din;
            tag_ram[wr_index]  <= mem_addr_q[24:INDEX_BITS];
        end
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        mem_addr_d  = mem_addr_q;
        fill_d      = fill_q;
        cpu_ack     = 1'b0;
        cpu_timeout = 1'b0;
        cpu_dout    = '0;
        mem_stb     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (flush_req) begin
                    valid_d = '0;
                end else if (cpu_stb) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    cpu_ack  = 1'b1;
                    cpu_dout = rd_line_q[word_off +: 32];
                    state_d  = IDLE;
                end else begin
                    mem_addr_d = cpu_addr[26:2];
                    state_d    = FILL;
                end
            end
            FILL: begin
                mem_stb = 1'b1;
                if (mem_ack) begin
                    valid_d[wr_index] = 1'b1;
                    fill_d            = mem_din;
                    state_d           = REPLY;
                end else if (mem_timeout) begin
                    state_d = TMO;
                end
            end
            REPLY: begin
                cpu_ack  = 1'b1;
                cpu_dout = fill_q[word_off +: 32];
                state_d  = IDLE;
            end
            TMO: begin
                cpu_timeout = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            mem_addr_q <= '0;
            fill_q     <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            mem_addr_q <= mem_addr_d;
            fill_q     <= fill_d;
        end
    end
endmodule
